// File: rtl/ysyx_23060136_mem_access_ctrl.sv
// MEM-stage load/store sequencer: one valid/ready bus request per memory instruction.
// Optional watchdog enabled by defining YSYX_23060136_MEM_TIMEOUT_EN.
module ysyx_23060136_mem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_i_commit,
  input  logic [DATA_W-1:0]   MEM_i_ALU_ALUout,
  input  logic                MEM_i_mem_to_reg,
  input  logic                MEM_i_mem_wen,
  input  logic [DATA_W-1:0]   MEM_i_wdata,
  input  logic [2:0]          MEM_i_func3,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err,
  output logic                MEM_o_stall_req,
  output logic                MEM_o_valid,
  output logic [DATA_W-1:0]   MEM_o_rdata,
  output logic                MEM_o_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_addr, r_wdata, r_rdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [2:0]          r_func3;
  logic [1:0]          r_lane;
  logic                r_wen, r_err;

  logic                w_mem_op, w_aligned, w_timeout;
  logic [1:0]          w_lane;
  logic [DATA_W/8-1:0] w_wmask;
  logic [DATA_W-1:0]   w_sh, w_load;

  assign w_mem_op = MEM_i_commit & (MEM_i_mem_to_reg | MEM_i_mem_wen);
  assign w_lane   = MEM_i_ALU_ALUout[1:0];
  assign w_sh     = mem_resp_rdata >> {r_lane, 3'b000};

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    w_aligned = 1'b1;
    w_wmask   = '1;
    case (MEM_i_func3[1:0])
      2'b00: w_wmask = 4'b0001 << w_lane;
      2'b01: begin
        w_wmask   = 4'b0011 << w_lane;
        w_aligned = ~w_lane[0];
      end
      2'b10: w_aligned = (w_lane == 2'b00);
      default: ;
    endcase
  end

  always_comb begin
    w_load = w_sh;
    case (r_func3)
      3'b000: w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100: w_load = {24'd0, w_sh[7:0]};
      3'b001: w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101: w_load = {16'd0, w_sh[15:0]};
      default: ;
    endcase
  end

`ifdef YSYX_23060136_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  // Counter value k means the access is in its k-th cycle since REQ entry.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_REQ || r_state == S_WAIT) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog: the access waits for the bus indefinitely.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op) w_next = w_aligned ? S_REQ : S_DONE;
      S_REQ:  if (w_timeout) w_next = S_DONE;
              else if (mem_req_ready) w_next = S_WAIT;
      S_WAIT: if (w_timeout || mem_resp_valid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the payload registers are reset too, because every output must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_func3 <= '0;
      r_lane  <= '0;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_mem_op) begin
          if (w_aligned) begin
            r_addr  <= {MEM_i_ALU_ALUout[DATA_W-1:2], 2'b00};
            r_wdata <= MEM_i_wdata << {w_lane, 3'b000};
            r_wmask <= w_wmask;
            r_func3 <= MEM_i_func3;
            r_lane  <= w_lane;
            r_wen   <= MEM_i_mem_wen;
            r_err   <= 1'b0;
          end else begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else if (r_state == S_WAIT && mem_resp_valid) begin
            r_err <= mem_resp_err;
            if (!r_wen) r_rdata <= mem_resp_err ? '0 : w_load;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_valid   = (r_state == S_REQ);
  assign mem_req_addr    = r_addr;
  assign mem_req_wen     = r_wen;
  assign mem_req_wdata   = r_wdata;
  assign mem_req_wmask   = r_wmask;
  assign MEM_o_stall_req = (r_state == S_IDLE && w_mem_op && w_aligned && !rst) ||
                           (r_state == S_REQ) || (r_state == S_WAIT);
  assign MEM_o_valid     = (r_state == S_DONE);
  assign MEM_o_err       = (r_state == S_DONE) && r_err;
  assign MEM_o_rdata     = r_rdata;

endmodule

// File: tb/tb_ysyx_23060136_mem_access_ctrl.sv
// Directed bench for the MEM-stage load/store sequencer; expected values are hand-computed.
module tb_ysyx_23060136_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_i_commit = 1'b0;
  logic [31:0] MEM_i_ALU_ALUout = '0;
  logic        MEM_i_mem_to_reg = 1'b0;
  logic        MEM_i_mem_wen = 1'b0;
  logic [31:0] MEM_i_wdata = '0;
  logic [2:0]  MEM_i_func3 = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        mem_resp_err = 1'b0;
  logic        MEM_o_stall_req;
  logic        MEM_o_valid;
  logic [31:0] MEM_o_rdata;
  logic        MEM_o_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  ysyx_23060136_mem_access_ctrl #(
    .DATA_W(32),
`ifdef YSYX_23060136_MEM_TIMEOUT_EN
    .TIMEOUT_CYC(8)
`else
    .TIMEOUT_CYC(255)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .MEM_i_commit(MEM_i_commit), .MEM_i_ALU_ALUout(MEM_i_ALU_ALUout),
    .MEM_i_mem_to_reg(MEM_i_mem_to_reg), .MEM_i_mem_wen(MEM_i_mem_wen),
    .MEM_i_wdata(MEM_i_wdata), .MEM_i_func3(MEM_i_func3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err),
    .MEM_o_stall_req(MEM_o_stall_req), .MEM_o_valid(MEM_o_valid),
    .MEM_o_rdata(MEM_o_rdata), .MEM_o_err(MEM_o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic load,
                       input logic [31:0] wdata);
    MEM_i_commit     = 1'b1;
    MEM_i_ALU_ALUout = addr;
    MEM_i_func3      = f3;
    MEM_i_mem_to_reg = load;
    MEM_i_mem_wen    = ~load;
    MEM_i_wdata      = wdata;
  endtask

  task automatic retire();
    MEM_i_commit     = 1'b0;
    MEM_i_mem_to_reg = 1'b0;
    MEM_i_mem_wen    = 1'b0;
    mem_resp_valid   = 1'b0;
    mem_resp_err     = 1'b0;
  endtask

  // Zero-wait load: IDLE, REQ, WAIT, DONE.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic berr, input logic [31:0] exp);
    issue(addr, f3, 1'b1, 32'h0);
    mem_req_ready = 1'b1;
    #1;
    check({tag, " stall_idle"}, 32'(MEM_o_stall_req), 32'd1);
    step();
    check({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
    check({tag, " req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    check({tag, " req_wen"}, 32'(mem_req_wen), 32'd0);
    check({tag, " stall_req"}, 32'(MEM_o_stall_req), 32'd1);
    step();
    check({tag, " wait_noreq"}, 32'(mem_req_valid), 32'd0);
    check({tag, " stall_wait"}, 32'(MEM_o_stall_req), 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    mem_resp_err   = berr;
    step();
    check({tag, " valid"}, 32'(MEM_o_valid), 32'd1);
    check({tag, " err"}, 32'(MEM_o_err), 32'(berr));
    check({tag, " rdata"}, MEM_o_rdata, exp);
    check({tag, " stall_done"}, 32'(MEM_o_stall_req), 32'd0);
    retire();
    step();
    check({tag, " valid_drop"}, 32'(MEM_o_valid), 32'd0);
    check({tag, " rdata_held"}, MEM_o_rdata, exp);
    last_rdata = exp;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check("rst req_valid", 32'(mem_req_valid), 32'd0);
    check("rst stall", 32'(MEM_o_stall_req), 32'd0);
    check("rst valid", 32'(MEM_o_valid), 32'd0);
    check("rst err", 32'(MEM_o_err), 32'd0);
    check("rst rdata", MEM_o_rdata, 32'd0);
    check("rst wmask", 32'(mem_req_wmask), 32'd0);
    rst = 1'b0;
    step();

    run_load("lw", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    run_load("lb", 32'h8000_0003, 3'b000, 32'h80FF_FFFF, 1'b0, 32'hFFFF_FF80);
    run_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_FFFF, 1'b0, 32'h0000_0080);
    run_load("lhu", 32'h8000_0002, 3'b101, 32'h1234_5678, 1'b0, 32'h0000_1234);
    run_load("lh", 32'h8000_0000, 3'b001, 32'h0000_8001, 1'b0, 32'hFFFF_8001);
    run_load("lb1", 32'h8000_0001, 3'b000, 32'h0000_7F00, 1'b0, 32'h0000_007F);

    // Store byte with a stalled bus; stray responses in REQ must be ignored.
    issue(32'h1000_0001, 3'b000, 1'b0, 32'h0000_00AB);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5555_5555;
    step();
    for (int i = 0; i < 5; i++) begin
      check("sb req_valid", 32'(mem_req_valid), 32'd1);
      check("sb wmask", 32'(mem_req_wmask), 32'h2);
      check("sb wdata", mem_req_wdata, 32'h0000_AB00);
      check("sb addr", mem_req_addr, 32'h1000_0000);
      check("sb wen", 32'(mem_req_wen), 32'd1);
      check("sb stall", 32'(MEM_o_stall_req), 32'd1);
      check("sb no_valid", 32'(MEM_o_valid), 32'd0);
      step();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    check("sb wait", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    step();
    check("sb valid", 32'(MEM_o_valid), 32'd1);
    check("sb err", 32'(MEM_o_err), 32'd0);
    check("sb rdata_kept", MEM_o_rdata, last_rdata);
    retire();
    step();

    // Halfword and word store lane/mask generation.
    issue(32'h1000_0002, 3'b001, 1'b0, 32'hCAFE_BABE);
    step();
    check("sh wmask", 32'(mem_req_wmask), 32'hC);
    check("sh wdata", mem_req_wdata, 32'hBABE_0000);
    step();
    mem_resp_valid = 1'b1;
    step();
    check("sh valid", 32'(MEM_o_valid), 32'd1);
    retire();
    step();
    issue(32'h1000_0008, 3'b010, 1'b0, 32'h0123_4567);
    step();
    check("sw wmask", 32'(mem_req_wmask), 32'hF);
    check("sw wdata", mem_req_wdata, 32'h0123_4567);
    step();
    mem_resp_valid = 1'b1;
    step();
    check("sw valid", 32'(MEM_o_valid), 32'd1);
    retire();
    step();

    // Misaligned word store: no request, no stall, error pulse next cycle.
    issue(32'h1000_0002, 3'b010, 1'b0, 32'hFFFF_FFFF);
    #1;
    check("mis stall", 32'(MEM_o_stall_req), 32'd0);
    check("mis noreq", 32'(mem_req_valid), 32'd0);
    step();
    check("mis valid", 32'(MEM_o_valid), 32'd1);
    check("mis err", 32'(MEM_o_err), 32'd1);
    check("mis rdata", MEM_o_rdata, 32'd0);
    check("mis noreq2", 32'(mem_req_valid), 32'd0);
    retire();
    step();
    check("mis err_drop", 32'(MEM_o_err), 32'd0);

    run_load("lw_buserr", 32'h8000_0010, 3'b010, 32'h1111_2222, 1'b1, 32'h0000_0000);

    // Reset while waiting for a response.
    issue(32'h8000_0020, 3'b010, 1'b1, 32'h0);
    mem_req_ready = 1'b1;
    step();
    step();
    check("rstw in_wait", 32'(MEM_o_stall_req), 32'd1);
    rst = 1'b1;
    retire();
    step();
    check("rstw req_valid", 32'(mem_req_valid), 32'd0);
    check("rstw stall", 32'(MEM_o_stall_req), 32'd0);
    check("rstw valid", 32'(MEM_o_valid), 32'd0);
    check("rstw err", 32'(MEM_o_err), 32'd0);
    check("rstw rdata", MEM_o_rdata, 32'd0);
    check("rstw addr", mem_req_addr, 32'd0);
    check("rstw wen", 32'(mem_req_wen), 32'd0);
    check("rstw wdata", mem_req_wdata, 32'd0);
    rst = 1'b0;
    step();
    run_load("lw_after_rst", 32'h8000_0024, 3'b010, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);

    // Bus that never accepts the request.
    issue(32'h2000_0000, 3'b010, 1'b0, 32'h0);
    mem_req_ready = 1'b0;
    step();
`ifdef YSYX_23060136_MEM_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      check("to waiting", 32'(MEM_o_valid), 32'd0);
    end
    check("to still_req", 32'(mem_req_valid), 32'd1);
    step();
    check("to valid", 32'(MEM_o_valid), 32'd1);
    check("to err", 32'(MEM_o_err), 32'd1);
    check("to req_drop", 32'(mem_req_valid), 32'd0);
    check("to stall_drop", 32'(MEM_o_stall_req), 32'd0);
    retire();
    step();
`else
    for (int i = 0; i < 100; i++) step();
    check("hang stall", 32'(MEM_o_stall_req), 32'd1);
    check("hang req_valid", 32'(mem_req_valid), 32'd1);
    check("hang no_valid", 32'(MEM_o_valid), 32'd0);
    retire();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
